// File: rtl/ifetch_bus_ctrl_if.sv
// Fetch-side request/response and memory read port for the instruction bus controller.
// Modport master is the controller; slave is the fetch stage plus memory.
interface ifetch_bus_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } ibus_resp_t;

    ibus_req_t         ireq;
    logic              update;
    ibus_resp_t        iresp;
    logic              iaddr_trans_finished;
    logic              misalign;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  ireq, update, mem_ready, mem_rvalid, mem_rdata,
        output iresp, iaddr_trans_finished, misalign, mem_valid, mem_addr
    );

    modport slave (
        output ireq, update, mem_ready, mem_rvalid, mem_rdata,
        input  iresp, iaddr_trans_finished, misalign, mem_valid, mem_addr
    );
endinterface

// File: rtl/ifetch_bus_ctrl.sv
// Instruction-side bus controller: one outstanding 32-bit read per fetch request,
// word held for fetch until update, stale responses dropped after a redirect.
//
// state  | meaning
// IDLE   | no transaction; latch an aligned ireq
// REQ    | mem_valid asserted with areg, waiting for mem_ready
// WAIT   | request accepted, waiting for mem_rvalid
// HOLD   | word presented to fetch until update
// DROP   | redirected after accept; swallow the next mem_rvalid
module ifetch_bus_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_bus_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] areg;
    logic [DATA_W-1:0] dreg;
    logic              mem_valid_q;
    logic              data_ok_q;
    logic              finished_q;
    logic              aligned;

    assign aligned = (bus.ireq.addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            areg        <= '0;
            dreg        <= '0;
            mem_valid_q <= 1'b0;
            data_ok_q   <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ireq.valid && aligned) begin
                        areg        <= bus.ireq.addr;
                        mem_valid_q <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Acceptance wins over a same-cycle redirect: the response must be drained.
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= bus.update ? S_DROP : S_WAIT;
                    end else if (bus.update) begin
                        mem_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.update) begin
                        state <= bus.mem_rvalid ? S_IDLE : S_DROP;
                    end else if (bus.mem_rvalid) begin
                        dreg       <= bus.mem_rdata;
                        data_ok_q  <= 1'b1;
                        finished_q <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.update) begin
                        data_ok_q  <= 1'b0;
                        finished_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.mem_rvalid) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    data_ok_q   <= 1'b0;
                    finished_q  <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid            = mem_valid_q;
    assign bus.mem_addr             = mem_valid_q ? areg : '0;
    assign bus.iaddr_trans_finished = finished_q;
    assign bus.misalign             = !rst && (state == S_IDLE) && bus.ireq.valid && !aligned;
    assign bus.iresp = '{addr_ok: mem_valid_q & bus.mem_ready,
                         data_ok: data_ok_q,
                         data:    data_ok_q ? dreg : '0};
endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// Directed bench for ifetch_bus_ctrl: per-cycle vector table plus a back-pressure sequence.
module tb_ifetch_bus_ctrl;
    logic clk;
    logic rst;

    ifetch_bus_ctrl_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    ifetch_bus_ctrl #(.ADDR_W(64), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] ia;
        logic        upd;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_mv;
        logic [63:0] e_ma;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_dat;
        logic        e_fin;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_0100;
    localparam logic [63:0] A2 = 64'h0000_0000_8000_0200;
    localparam logic [63:0] A3 = 64'h0000_0000_8000_0300;
    localparam logic [63:0] A4 = 64'h0000_0000_8000_0400;
    localparam logic [63:0] AM = 64'h0000_0000_8000_0002;

    task automatic add(input logic r, input logic iv, input logic [63:0] ia, input logic upd,
                       input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic mv, input logic [63:0] ma, input logic aok, input logic dok,
                       input logic [31:0] dat, input logic fin, input logic mis);
        vec_t v;
        v = '{rst: r, iv: iv, ia: ia, upd: upd, rdy: rdy, rv: rv, rd: rd,
              e_mv: mv, e_ma: ma, e_aok: aok, e_dok: dok, e_dat: dat, e_fin: fin, e_mis: mis};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [63:0] ia, input logic upd,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        rst             = r;
        bus.ireq.valid  = iv;
        bus.ireq.addr   = ia;
        bus.update      = upd;
        bus.mem_ready   = rdy;
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rd;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int accepts;

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);

        //   rst iv  ia   upd rdy rv  rd             mv  ma  aok dok dat           fin mis
        // reset state
        add(1, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // basic fetch: data_ok three cycles after valid, held (rvalid in HOLD ignored)
        add(0, 1, A0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A0, 0, 1, 0, '0,                 1, A0, 1, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 1, 32'h0000_0013,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 1, 32'h13,        1, 0);
        add(0, 0, '0, 0, 0, 1, 32'hFFFF_FFFF,      0, '0, 0, 1, 32'h13,        1, 0);
        add(0, 0, '0, 1, 0, 0, '0,                 0, '0, 0, 1, 32'h13,        1, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // redirect in WAIT, stale DEADBEEF dropped, new address fetched
        add(0, 1, A0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A0, 0, 1, 0, '0,                 1, A0, 1, 0, '0,            0, 0);
        add(0, 1, A1, 1, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A1, 0, 0, 1, 32'hDEAD_BEEF,      0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A1, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A1, 0, 1, 0, '0,                 1, A1, 1, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 1, 32'h0010_0073,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 1, 32'h0010_0073, 1, 0);
        add(0, 0, '0, 1, 0, 0, '0,                 0, '0, 0, 1, 32'h0010_0073, 1, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // update and rvalid together in WAIT: discarded, IDLE, rvalid in IDLE ignored
        add(0, 1, A2, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 1, A2, 0, 1, 0, '0,                 1, A2, 1, 0, '0,            0, 0);
        add(0, 0, '0, 1, 0, 1, 32'h1111_1111,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 1, 32'h2222_2222,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // misaligned request: flagged, no bus access
        add(0, 1, AM, 0, 1, 0, '0,                 0, '0, 0, 0, '0,            0, 1);
        add(0, 1, AM, 0, 1, 0, '0,                 0, '0, 0, 0, '0,            0, 1);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // redirect in REQ before accept: request withdrawn
        add(0, 1, A0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 1, 0, 0, '0,                 1, A0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // redirect in REQ with same-cycle accept: DROP, new ireq not latched until IDLE
        add(0, 1, A0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 1, 1, 0, '0,                 1, A0, 1, 0, '0,            0, 0);
        add(0, 1, A1, 0, 1, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 1, 32'h3333_3333,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        // reset in WAIT, then a late rvalid ignored
        add(0, 1, A0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 1, 0, '0,                 1, A0, 1, 0, '0,            0, 0);
        add(1, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 1, 32'hCAFE_F00D,      0, '0, 0, 0, '0,            0, 0);
        add(0, 0, '0, 0, 0, 0, '0,                 0, '0, 0, 0, '0,            0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].upd,
                  vecs[i].rdy, vecs[i].rv, vecs[i].rd);
            #1;
            chk($sformatf("row%0d mem_valid", i), 64'(bus.mem_valid), 64'(vecs[i].e_mv));
            chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].e_ma);
            chk($sformatf("row%0d addr_ok", i), 64'(bus.iresp.addr_ok), 64'(vecs[i].e_aok));
            chk($sformatf("row%0d data_ok", i), 64'(bus.iresp.data_ok), 64'(vecs[i].e_dok));
            chk($sformatf("row%0d data", i), 64'(bus.iresp.data), 64'(vecs[i].e_dat));
            chk($sformatf("row%0d finished", i), 64'(bus.iaddr_trans_finished), 64'(vecs[i].e_fin));
            chk($sformatf("row%0d misalign", i), 64'(bus.misalign), 64'(vecs[i].e_mis));
        end

        // back-pressure: mem_ready low five cycles, address changes ignored, single accept
        accepts = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, A3, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("bp idle mem_valid", 64'(bus.mem_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, A4, 1'b0, 1'b0, 1'b0, '0);
            #1;
            chk($sformatf("bp stall%0d mem_valid", k), 64'(bus.mem_valid), 64'd1);
            chk($sformatf("bp stall%0d mem_addr", k), bus.mem_addr, A3);
            accepts += int'(bus.iresp.addr_ok);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("bp accept addr_ok", 64'(bus.iresp.addr_ok), 64'd1);
        chk("bp accept mem_addr", bus.mem_addr, A3);
        accepts += int'(bus.iresp.addr_ok);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("bp wait mem_valid", 64'(bus.mem_valid), 64'd0);
        accepts += int'(bus.iresp.addr_ok);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_0093);
        #1;
        accepts += int'(bus.iresp.addr_ok);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("bp hold data_ok", 64'(bus.iresp.data_ok), 64'd1);
        chk("bp hold data", 64'(bus.iresp.data), 64'h93);
        chk("bp accept count", 64'(accepts), 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("bp released data_ok", 64'(bus.iresp.data_ok), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
